// File: rtl/uart_pkg.sv
// uart_pkg: receiver line states and oversampling constants shared by the UART receive path
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: single-cycle tick every DIV clocks (16x oversample strobe)
// Ports: clk (rising edge), rst (async active-high), tick (one-cycle pulse every DIV clocks)
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 1");
  end
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(DIV - 1);
  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_packet_rx.sv
// uart_packet_rx: 8N1 UART receiver with a 4-phase packet_ready/packet_ack holding register
// Ports: clk, rst (async active-high), rx (idle high), packet_ack (consumer took byte),
//        packet_ready/uart_packet (held byte), framing_err/overrun_err/parity_err (one-cycle pulses)
// Optional even parity bit after data when UART_RX_PARITY_EN is defined; otherwise parity_err is 0.
module uart_packet_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       packet_ack,
  output logic       packet_ready,
  output logic [7:0] uart_packet,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       parity_err
);
  localparam int DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic tick;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  state_t state_q, state_d;
  logic       sync1_q, sync2_q;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d, pkt_q, pkt_d;
  logic [1:0] flush_q, flush_d;
  logic       bad_q, bad_d, ready_q, ready_d;
  logic       ferr_q, ferr_d, perr_q, perr_d, oerr_q, oerr_d;
  logic       last, mid;
  assign last = tcnt_q == 4'(OVERSAMPLE - 1);
  assign mid  = tcnt_q == 4'(MID_SAMPLE - 1);
  // flush_q lets the synchronizer refill with real line values after reset; the first
  // decision out of reset then goes through WAIT_IDLE so a frame cut by reset is ignored.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    bad_d   = bad_q;
    flush_d = &flush_q ? flush_q : flush_q + 2'd1;
    ready_d = ready_q && !packet_ack;
    pkt_d   = pkt_q;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    oerr_d  = 1'b0;
    if (tick && state_q inside {START, DATA, PARITY, STOP}) tcnt_d = last ? '0 : tcnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        if (flush_q == 2'd2) state_d = WAIT_IDLE;
        else if (&flush_q && tick && !sync2_q) begin
          state_d = START;
          tcnt_d  = '0;
        end
      end
      START: if (tick && mid) begin
        tcnt_d  = '0;
        bcnt_d  = '0;
        state_d = sync2_q ? IDLE : DATA;
      end
      DATA: if (tick && last) begin
        shift_d = {sync2_q, shift_q[7:1]};
        bcnt_d  = bcnt_q + 3'd1;
        if (&bcnt_q) begin
          bad_d   = 1'b0;
          state_d = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY: if (tick && last) begin
        bad_d   = sync2_q != ^shift_q;
        state_d = STOP;
      end
      // Error reporting is deferred to the stop sample so a byte raises at most one
      // error, with framing taking precedence over parity and parity over overrun.
      STOP: if (tick && last) begin
        if (!sync2_q) begin
          ferr_d  = 1'b1;
          state_d = WAIT_IDLE;
        end else begin
          state_d = IDLE;
          if (bad_q) perr_d = 1'b1;
          else if (ready_q || packet_ack) oerr_d = 1'b1;
          else begin
            pkt_d   = shift_q;
            ready_d = 1'b1;
          end
        end
      end
      WAIT_IDLE: if (sync2_q) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      flush_q <= '0;
      bad_q   <= 1'b0;
      ready_q <= 1'b0;
      pkt_q   <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      flush_q <= flush_d;
      bad_q   <= bad_d;
      ready_q <= ready_d;
      pkt_q   <= pkt_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      oerr_q  <= oerr_d;
    end
  end
  assign packet_ready = ready_q;
  assign uart_packet  = pkt_q;
  assign framing_err  = ferr_q;
  assign overrun_err  = oerr_q;
  assign parity_err   = PAR_EN && perr_q;
endmodule
